// File: rtl/led_scan_pkg.sv
// Shared types, sizes and the 7-segment decoder for the LED matrix scanner.
package led_scan_pkg;

    localparam int ROWS    = 8;
    localparam int COLS    = 8;
    localparam int COLOURS = 3;

    typedef enum logic [1:0] {
        COL_R = 2'd0,
        COL_G = 2'd1,
        COL_B = 2'd2
    } colour_e;

    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Segment order is {a,b,c,d,e,f,g}, active-low; non-BCD codes show nothing.
    function automatic logic [6:0] seg7(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/scan_timebase.sv
// Row-period prescaler and row counter. row and blank describe the cycle that
// follows the coming clock edge, so the top can register its outputs from them.
module scan_timebase
    import led_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 6250,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic       row_tick,
    output logic       blank,
    output logic [2:0] row
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    row_q, row_d;

    always_comb begin
        row_tick = (presc_q == PW'(SCAN_DIV - 1));
        presc_d  = row_tick ? '0 : presc_q + PW'(1);
        row_d    = row_tick ? row_q + 3'd1 : row_q;
        blank    = (presc_d < PW'(BLANK_CYCLES));
        row      = row_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            row_q   <= '0;
        end else begin
            presc_q <= presc_d;
            row_q   <= row_d;
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered 8x8 RGB matrix scanner with swap-at-frame-boundary control.
// Optional 2-digit 7-segment multiplexer is enabled by defining SEG_MUX_EN.
module led_matrix_scanner
    import led_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 6250,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_row,
    input  logic [1:0]  wr_color,
    input  logic [7:0]  wr_data,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        frame_start,
    output logic [7:0]  led_r,
    output logic [7:0]  led_g,
    output logic [7:0]  led_b,
    output logic [2:0]  row_sel,
    output logic        led_en,
`ifdef SEG_MUX_EN
    input  logic [3:0]  digit0,
    input  logic [3:0]  digit1,
    output logic [6:0]  seg,
    output logic [1:0]  com,
`endif
    output swap_state_e dbg_swap_state
);

    logic       row_tick;
    logic       blank_nx;
    logic [2:0] row_nx;
    logic       wrap;
    logic       swap_fire;

    scan_timebase #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timebase (
        .clk      (CLK),
        .rst      (reset),
        .row_tick (row_tick),
        .blank    (blank_nx),
        .row      (row_nx)
    );

    assign wrap = row_tick && (row_nx == 3'd0);

    // Swap FSM: a request waits for the next 7->0 wrap; repeats are absorbed.
    swap_state_e state_q, state_d;

    always_comb begin
        state_d   = state_q;
        swap_fire = 1'b0;
        case (state_q)
            SWAP_IDLE: begin
                if (swap_req) state_d = SWAP_PENDING;
            end
            SWAP_PENDING: begin
                if (wrap) begin
                    swap_fire = 1'b1;
                    state_d   = SWAP_IDLE;
                end
            end
            default: state_d = SWAP_IDLE;
        endcase
    end

    assign dbg_swap_state = state_q;

    logic front_q, front_d;

    assign front_d = front_q ^ swap_fire;

    // Frame store. Writes target the bank that is back before any swap this
    // cycle, so a write coinciding with a swap is shown by the new front.
    logic [7:0] bank_q [2][ROWS][COLOURS];
    logic [7:0] bank_d [2][ROWS][COLOURS];

    always_comb begin
        bank_d = bank_q;
        if (wr_en && (wr_color != 2'd3)) begin
            bank_d[~front_q][wr_row][wr_color] = wr_data;
        end
    end

    logic [7:0] led_r_q, led_r_d;
    logic [7:0] led_g_q, led_g_d;
    logic [7:0] led_b_q, led_b_d;
    logic [2:0] row_sel_q, row_sel_d;
    logic       led_en_q, led_en_d;
    logic       swap_ack_q, swap_ack_d;
    logic       frame_start_q, frame_start_d;

    always_comb begin
        row_sel_d     = row_nx;
        led_en_d      = 1'b1;
        swap_ack_d    = swap_fire;
        frame_start_d = wrap;
        if (blank_nx) begin
            led_r_d = 8'hFF;
            led_g_d = 8'hFF;
            led_b_d = 8'hFF;
        end else begin
            led_r_d = ~bank_d[front_d][row_nx][int'(COL_R)];
            led_g_d = ~bank_d[front_d][row_nx][int'(COL_G)];
            led_b_d = ~bank_d[front_d][row_nx][int'(COL_B)];
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q       <= SWAP_IDLE;
            front_q       <= 1'b0;
            led_r_q       <= 8'hFF;
            led_g_q       <= 8'hFF;
            led_b_q       <= 8'hFF;
            row_sel_q     <= 3'd0;
            led_en_q      <= 1'b0;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            front_q       <= front_d;
            led_r_q       <= led_r_d;
            led_g_q       <= led_g_d;
            led_b_q       <= led_b_d;
            row_sel_q     <= row_sel_d;
            led_en_q      <= led_en_d;
            swap_ack_q    <= swap_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLOURS; c++) begin
                        bank_q[b][r][c] <= '0;
                    end
                end
            end
        end else begin
            bank_q <= bank_d;
        end
    end

    assign led_r       = led_r_q;
    assign led_g       = led_g_q;
    assign led_b       = led_b_q;
    assign row_sel     = row_sel_q;
    assign led_en      = led_en_q;
    assign swap_ack    = swap_ack_q;
    assign frame_start = frame_start_q;

`ifdef SEG_MUX_EN
    // Digit select flips on every row tick; com=10 is the ones digit.
    logic [1:0] com_q, com_d;
    logic [6:0] seg_q, seg_d;

    always_comb begin
        com_d = row_tick ? ~com_q : com_q;
        seg_d = seg7((com_d == 2'b10) ? digit0 : digit1);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            com_q <= 2'b10;
            seg_q <= SEG_BLANK;
        end else begin
            com_q <= com_d;
            seg_q <= seg_d;
        end
    end

    assign com = com_q;
    assign seg = seg_q;
`endif

endmodule
